// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave RAM with registered-feedback incrementing and wrapping bursts.
// Storage is a word-indexed array `mem` reachable hierarchically for preload and inspection.
module wb_burst_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o
);

    localparam int NB  = DW / 8;
    localparam int LB  = $clog2(NB);
    localparam int NW  = DEPTH / NB;
    localparam int WAW = AW - LB;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [DW-1:0]  mem [0:NW-1];

    state_t         state_r, state_nxt_s;
    logic [WAW-1:0] addr_r, addr_nxt_s;
    logic [WAW-1:0] rd_idx_s;
    logic [WAW-1:0] adr_word_s;
    logic [DW-1:0]  dat_r;
    logic           ack_r, ack_nxt_s;
    logic           err_r, err_nxt_s;
    logic           load_s;
    logic           valid_s;
    logic           cti_ok_s;
    logic           wr_en_s;
    logic           adr_unused_s;

    // Wrapping bursts advance only the low 2/3/4 word-address bits; linear advances all of them.
    function automatic logic [WAW-1:0] next_addr(input logic [WAW-1:0] a, input logic [1:0] bte);
        logic [WAW-1:0] mask;
        logic [WAW-1:0] inc;
        case (bte)
            2'b00:   mask = '1;
            2'b01:   mask = WAW'(4'h3);
            2'b10:   mask = WAW'(4'h7);
            2'b11:   mask = WAW'(4'hF);
            default: mask = '1;
        endcase
        inc = a + WAW'(1'b1);
        return (a & ~mask) | (inc & mask);
    endfunction

    assign valid_s      = wb_cyc_i & wb_stb_i;
    assign cti_ok_s     = (wb_cti_i == 3'b000) || (wb_cti_i == 3'b010) || (wb_cti_i == 3'b111);
    assign adr_word_s   = wb_adr_i[AW-1:LB];
    assign adr_unused_s = ^wb_adr_i[LB-1:0];
    assign wr_en_s      = (state_r == ACTIVE) && valid_s && wb_we_i;

    // Next-state, beat address and registered-output decisions.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        rd_idx_s    = addr_r;
        ack_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_s && cti_ok_s) begin
                    addr_nxt_s  = adr_word_s;
                    rd_idx_s    = adr_word_s;
                    load_s      = 1'b1;
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = ACTIVE;
                end else if (valid_s) begin
                    // A held bad request must not stretch err beyond one cycle.
                    err_nxt_s = ~err_r;
                end else begin
                    err_nxt_s = 1'b0;
                end
            end
            ACTIVE: begin
                if (valid_s && (wb_cti_i == 3'b010)) begin
                    addr_nxt_s = next_addr(addr_r, wb_bte_i);
                    rd_idx_s   = next_addr(addr_r, wb_bte_i);
                    load_s     = 1'b1;
                    ack_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, beat address and registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            addr_r  <= '0;
            dat_r   <= '0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            ack_r   <= ack_nxt_s;
            err_r   <= err_nxt_s;
            if (load_s) begin
                dat_r <= mem[rd_idx_s];
            end
        end
    end

    // Byte-lane writes at the current beat address; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en_s && wb_sel_i[i]) begin
                mem[addr_r][i*8 +: 8] <= wb_dat_i[i*8 +: 8];
            end
        end
    end

    assign wb_dat_o = dat_r;
    assign wb_ack_o = ack_r;
    assign wb_err_o = err_r;

endmodule

// File: tb/tb_wb_burst_ram.sv
// Self-checking bench for wb_burst_ram: classic vector table, burst/abort/reset sequences,
// and a random soak checked against a word-array reference model.
module tb_wb_burst_ram;

    localparam int NW = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;

    int errors = 0;
    int checks = 0;
    logic [31:0] ref_mem [0:NW-1];

    typedef struct {
        logic [8:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    wb_burst_ram dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        sel = 4'h0; dat_i = 32'h0; adr = 9'h0;
    endtask

    task automatic ref_write(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Word address of beat k: linear wraps over the whole memory, wrap-N inside an N-aligned block.
    function automatic int beat_addr(input int start, input logic [1:0] b, input int k);
        int n;
        n = (b == 2'b00) ? NW : (2 << b);
        return (start - start % n) + (start % n + k) % n;
    endfunction

    task automatic classic(input vec_t v, input string name);
        cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat_i = v.dat; sel = v.sel;
        cti = 3'b000; bte = 2'b00;
        @(posedge clk); #1;
        check({name, " ack"}, {31'h0, ack}, 32'h1);
        if (!v.we) check({name, " dat"}, dat_o, v.exp);
        @(posedge clk); #1;
        check({name, " ack low"}, {31'h0, ack}, 32'h0);
        if (v.we) ref_write(int'(v.adr[8:2]), v.dat, v.sel);
        idle_bus();
        @(posedge clk); #1;
    endtask

    task automatic burst(input int start, input logic [1:0] b, input int n,
                         input logic wr, input bit abort, input string tag);
        int a;
        logic [31:0] wd;
        logic [3:0]  s;
        cyc = 1'b1; stb = 1'b1; we = wr; bte = b; cti = 3'b010;
        adr = 9'(start * 4); dat_i = 32'h0; sel = 4'h0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            a = beat_addr(start, b, k);
            check({tag, " ack"}, {31'h0, ack}, 32'h1);
            check({tag, " dat"}, dat_o, ref_mem[a]);
            wd = $urandom;
            s  = wr ? 4'($urandom_range(1, 15)) : 4'h0;
            adr = 9'(a * 4); dat_i = wd; sel = s;
            if (k == n - 1) begin
                if (abort) begin
                    cyc = 1'b0; stb = 1'b0;
                end else begin
                    cti = 3'b111;
                end
            end
            if (wr && !(abort && k == n - 1)) ref_write(a, wd, s);
        end
        @(posedge clk); #1;
        check({tag, " end ack low"}, {31'h0, ack}, 32'h0);
        idle_bus();
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{9'h010, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0};
        vecs[1] = '{9'h010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{9'h010, 32'h00000055, 4'h1, 1'b1, 32'h0};
        vecs[3] = '{9'h010, 32'h0,        4'h0, 1'b0, 32'hDEADBE55};
        vecs[4] = '{9'h014, 32'h11223344, 4'hF, 1'b1, 32'h0};
        vecs[5] = '{9'h014, 32'hAABBCCDD, 4'h6, 1'b1, 32'h0};
        vecs[6] = '{9'h014, 32'h0,        4'h0, 1'b0, 32'h11BBCC44};
        vecs[7] = '{9'h018, 32'hCAFEF00D, 4'hC, 1'b1, 32'h0};
        vecs[8] = '{9'h01B, 32'h0,        4'h0, 1'b0, 32'hCAFE0000};
        vecs[9] = '{9'h010, 32'h0,        4'h0, 1'b0, 32'hDEADBE55};

        rst = 1'b0;
        idle_bus();
        for (int i = 0; i < NW; i++) begin
            dut.mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset held with a valid request pending.
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'h0, ack}, 32'h0);
        check("reset err", {31'h0, err}, 32'h0);
        check("reset dat", dat_o, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first ack latency", {31'h0, ack}, 32'h1);
        @(posedge clk); #1;
        check("first ack drop", {31'h0, ack}, 32'h0);
        idle_bus();
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) classic(vecs[i], $sformatf("vec%0d", i));

        // Linear 32-beat read over randomized backdoor contents.
        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = $urandom;
            dut.mem[i] = ref_mem[i];
        end
        burst(16, 2'b00, 32, 1'b0, 1'b0, "linear rd");

        // Wrap-4 from word 3: read, then write the same pattern and read it back classically.
        check("wrap4 order", beat_addr(3, 2'b01, 1), 0);
        burst(3, 2'b01, 4, 1'b0, 1'b0, "wrap4 rd");
        burst(3, 2'b01, 4, 1'b1, 1'b0, "wrap4 wr");
        for (int w = 0; w < 4; w++) begin
            vec_t v;
            v = '{9'(w * 4), 32'h0, 4'h0, 1'b0, ref_mem[w]};
            classic(v, $sformatf("wrap4 verify%0d", w));
        end
        burst(45, 2'b10, 8, 1'b1, 1'b0, "wrap8 wr");
        burst(45, 2'b10, 8, 1'b0, 1'b0, "wrap8 rd");
        burst(77, 2'b11, 16, 1'b0, 1'b0, "wrap16 rd");

        // Unsupported cycle type: one-cycle err even while held, no ack, no write.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b001; adr = 9'h010;
        dat_i = 32'h12345678; sel = 4'hF;
        @(posedge clk); #1;
        check("err raised", {31'h0, err}, 32'h1);
        check("err no ack", {31'h0, ack}, 32'h0);
        @(posedge clk); #1;
        check("err one cycle", {31'h0, err}, 32'h0);
        check("err still no ack", {31'h0, ack}, 32'h0);
        idle_bus();
        @(posedge clk); #1;
        check("err mem untouched", dut.mem[4], ref_mem[4]);

        // Abort by dropping cyc mid-burst, then restart elsewhere.
        burst(20, 2'b00, 5, 1'b1, 1'b1, "abort wr");
        burst(50, 2'b00, 6, 1'b0, 1'b0, "restart rd");
        burst(20, 2'b00, 5, 1'b0, 1'b0, "abort verify");

        // Asynchronous reset mid-burst kills the pending write.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00;
        adr = 9'(40 * 4); dat_i = 32'h5A5A5A5A; sel = 4'hF;
        @(posedge clk); #1;
        check("rst mid ack", {31'h0, ack}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rst async ack", {31'h0, ack}, 32'h0);
        check("rst async dat", dat_o, 32'h0);
        @(posedge clk); #1;
        idle_bus();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst write dropped", dut.mem[40], ref_mem[40]);

        // Random soak of 32-word linear bursts.
        for (int t = 0; t < 24; t++) begin
            burst($urandom_range(0, 96), 2'b00, 32, 1'($urandom_range(0, 1)), 1'b0,
                  $sformatf("soak%0d", t));
        end
        for (int i = 0; i < NW; i++) check($sformatf("final mem%0d", i), dut.mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_burst_ram.md
Name: wb_burst_ram

Overview:
- Synthesizable Wishbone B3 slave memory with registered-feedback burst support (incrementing and wrapping bursts).
- Serves as the backing store for DMA/stream masters such as the stream writer, and as a simulation memory model.
- Contents are preloadable through a hierarchical word-indexed array.

Parameters:
- DW, 32: data width in bits; byte lanes = DW/8.
- DEPTH, 512: memory size in bytes; power of two, multiple of DW/8.
- AW, $clog2(DEPTH): byte-address width used by the slave.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  AW  byte address; bits [1:0] ignored; word index = wb_adr_i[AW-1:2].
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte-lane write enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16 (in words).
- wb_dat_o  out  DW  read data, registered.
- wb_ack_o  out  1  acknowledge, registered.
- wb_err_o  out  1  error, registered.

Behaviour:
Storage:
- Array mem[0:DEPTH/(DW/8)-1] of DW bits, word-indexed, hierarchically accessible for backdoor init/inspection.
- Memory is not cleared by reset.

Reset (rst=0, async):
- wb_ack_o=0, wb_err_o=0, wb_dat_o=0, internal beat address A=0, state IDLE.

Definitions:
- valid = wb_cyc_i & wb_stb_i.

IDLE (wb_ack_o=0, wb_err_o=0):
- If valid and wb_cti_i is in {000, 010, 111}: A<=wb_adr_i[AW-1:2]; wb_dat_o<=mem[wb_adr_i word]; wb_ack_o<=1; go to ACTIVE.
- If valid and wb_cti_i is 001 or 011..110: wb_err_o<=1 for exactly one cycle. No memory access, no ack. Then IDLE.

ACTIVE (wb_ack_o=1; current beat address A):
- At each edge with valid: if wb_we_i, write wb_dat_i into mem[A] on lanes where wb_sel_i=1. Lanes with sel=0 are unchanged.
- If valid and wb_cti_i==010: A<=next(A); wb_dat_o<=mem[next(A)]; wb_ack_o stays 1. This gives one beat per cycle.
- Otherwise (cti 000/111, or valid dropped): wb_ack_o<=0; go to IDLE. A write with valid happens at this edge as above.
- Consequence: a classic cycle costs 2 clocks per access.

next(A):
- bte 00: A+1, wrapping modulo memory size.
- bte 01/10/11: low 2/3/4 bits increment with wrap; upper bits held.

Burst addressing:
- Beat addresses after the first come from A, not wb_adr_i. The master must drive matching addresses.

Read data:
- wb_dat_o reflects mem at the current beat address whenever wb_ack_o=1.
- A write to the same address lands the same edge that the next beat's read is sampled, and the next beat uses the new address. Reading the just-written word therefore requires a later beat or a new cycle.

Wait state:
- wb_stb_i low or wb_cyc_i low mid-burst drops ack on the next edge.
- Resumption is treated as a new first beat using wb_adr_i.

Other rules:
- wb_ack_o and wb_err_o are never high together.
- Reset asserted mid-burst: outputs clear immediately; in-flight write not performed unless its edge already occurred.

Test Plan:
1. Reset: hold rst=0 with stb active → ack=0, err=0, dat_o=0. Release → first ack 1 clock after valid.
2. Classic read/write: write 0xDEADBEEF to 0x10 with sel=1111, cti=000 → ack 1 cycle then low. Read 0x10 → 0xDEADBEEF. Byte write 0x00000055 with sel=0001 → read 0xDEADBE55.
3. Linear burst read: backdoor mem[i]=random; cti=010, bte=00, start 0x40, 32 beats, last with cti=111 → ack high 32 consecutive cycles; data equals mem[16..47] in order; ack low after last.
4. Wrap-4 burst: start 0x0C, bte=01, 4 beats → words 3,0,1,2 returned. Same pattern as a write burst → those words updated.
5. Error/abort: cti=001 → single-cycle err, no ack, memory unchanged. Deassert cyc mid linear burst → ack low next edge; restart at new address returns correct data.
6. Random soak: 24 bursts of 32 words at random word-aligned starts within 0..384 → every word matches backdoor contents.
